car_alarm_chime: RTL and testbench

- Consumer end of the car warning alarm line: takes the level `Alarm` request from the warning logic and turns it into a timed audible beep pattern plus a dashboard lamp.
- Supports a driver mute acknowledge.
- Escalates to non-mutable continuous bursts if the alarm persists.
- Sits between the warning combinational logic and the buzzer/lamp drivers.

---
 rtl/car_alarm_chime.sv | 139 +++++++++++++
 tb/tb_car_alarm_chime.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/car_alarm_chime.sv
// Consumer end of the car warning alarm line: turns a level alarm request into a
// timed beep pattern, a warning lamp and a non-mutable escalation mode.
module car_alarm_chime #(
  parameter int TICK_DIV   = 1000,
  parameter int BEEP_ON_T  = 2,
  parameter int BEEP_OFF_T = 3,
  parameter int BEEPS      = 4,
  parameter int SILENCE_T  = 10,
  parameter int ESC_BURSTS = 3
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Alarm,
  input  logic Ack,
  output logic Buzzer,
  output logic Lamp,
  output logic Escalated
);

  localparam int MAX_T = (BEEP_ON_T > BEEP_OFF_T) ?
                         ((BEEP_ON_T > SILENCE_T) ? BEEP_ON_T : SILENCE_T) :
                         ((BEEP_OFF_T > SILENCE_T) ? BEEP_OFF_T : SILENCE_T);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int CW = $clog2(BEEPS + 1);
  localparam int BW = $clog2(ESC_BURSTS + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] ON_LAST  = TW'(BEEP_ON_T - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(BEEP_OFF_T - 1);
  localparam logic [TW-1:0] SIL_LAST = TW'(SILENCE_T - 1);
  localparam logic [CW-1:0] BEEPS_C  = CW'(BEEPS);
  localparam logic [BW-1:0] ESC_C    = BW'(ESC_BURSTS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BEEP_ON  = 3'd1,
    BEEP_OFF = 3'd2,
    SILENCE  = 3'd3,
    MUTED    = 3'd4
  } chimeState_t;

  chimeState_t state, stateNext;
  logic [PW-1:0] prescaler, prescalerNext;
  logic [TW-1:0] tickCnt, tickCntNext;
  logic [CW-1:0] beepCnt, beepCntNext, beepInc;
  logic [BW-1:0] burstCnt, burstCntNext, burstInc;
  logic escNext, tick, phaseEnd, timedState;

  // Next-state logic; priority is Alarm drop, then Ack, then phase timing.
  always_comb begin
    stateNext     = state;
    prescalerNext = prescaler;
    tickCntNext   = tickCnt;
    beepCntNext   = beepCnt;
    burstCntNext  = burstCnt;
    escNext       = Escalated;
    tick          = (prescaler == PRE_LAST);
    beepInc       = beepCnt + CW'(1);
    burstInc      = burstCnt + BW'(1);
    timedState    = (state == BEEP_ON) || (state == BEEP_OFF) || (state == SILENCE);
    case (state)
      BEEP_ON:  phaseEnd = tick && (tickCnt == ON_LAST);
      BEEP_OFF: phaseEnd = tick && (tickCnt == OFF_LAST);
      SILENCE:  phaseEnd = tick && (tickCnt == SIL_LAST);
      default:  phaseEnd = 1'b0;
    endcase

    if (!Alarm) begin
      stateNext    = IDLE;
      beepCntNext  = '0;
      burstCntNext = '0;
      escNext      = 1'b0;
    end else if (state == IDLE) begin
      stateNext    = BEEP_ON;
      beepCntNext  = '0;
      burstCntNext = '0;
    end else if (timedState) begin
      if (Ack && !Escalated) begin
        stateNext = MUTED;
      end else if (phaseEnd) begin
        case (state)
          BEEP_ON: stateNext = BEEP_OFF;
          BEEP_OFF: begin
            if (beepInc == BEEPS_C) begin
              beepCntNext = '0;
              stateNext   = Escalated ? BEEP_ON : SILENCE;
            end else begin
              beepCntNext = beepInc;
              stateNext   = BEEP_ON;
            end
          end
          default: begin
            if (burstCnt != ESC_C) burstCntNext = burstInc;
            if (burstInc == ESC_C) escNext = 1'b1;
            stateNext = BEEP_ON;
          end
        endcase
      end
    end

    // Every state change restarts the phase timing from zero.
    if (stateNext != state) begin
      prescalerNext = '0;
      tickCntNext   = '0;
    end else if (timedState) begin
      if (tick) begin
        prescalerNext = '0;
        tickCntNext   = tickCnt + TW'(1);
      end else begin
        prescalerNext = prescaler + PW'(1);
      end
    end
  end

  // Outputs are decoded from the next state so they switch with the state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      prescaler <= '0;
      tickCnt   <= '0;
      beepCnt   <= '0;
      burstCnt  <= '0;
      Buzzer    <= 1'b0;
      Lamp      <= 1'b0;
      Escalated <= 1'b0;
    end else begin
      state     <= stateNext;
      prescaler <= prescalerNext;
      tickCnt   <= tickCntNext;
      beepCnt   <= beepCntNext;
      burstCnt  <= burstCntNext;
      Buzzer    <= (stateNext == BEEP_ON);
      Lamp      <= (stateNext != IDLE);
      Escalated <= escNext;
    end
  end

endmodule

// File: tb/tb_car_alarm_chime.sv
// Self-checking bench for car_alarm_chime: an arithmetic timeline model of the
// beep pattern predicts Buzzer/Lamp/Escalated for directed and random stimulus.
module tb_car_alarm_chime;

  localparam int TD    = 2;
  localparam int ON_T  = 2;
  localparam int OFF_T = 1;
  localparam int NB    = 2;
  localparam int SIL_T = 3;
  localparam int ESC   = 2;

  localparam int BEEP_LEN  = (ON_T + OFF_T) * TD;
  localparam int BURST_LEN = NB * BEEP_LEN;
  localparam int CYCLE_LEN = BURST_LEN + SIL_T * TD;
  localparam int ESC_START = ESC * CYCLE_LEN;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic Alarm = 1'b0;
  logic Ack = 1'b0;
  logic Buzzer, Lamp, Escalated;

  int vectors = 0;
  int miscompares = 0;

  // Model: mK is the 1-based cycle count since the pattern started.
  bit mActive = 1'b0;
  bit mMuted = 1'b0;
  int mK = 0;
  logic expBuzzer = 1'b0;
  logic expLamp = 1'b0;
  logic expEsc = 1'b0;

  car_alarm_chime #(
    .TICK_DIV(TD), .BEEP_ON_T(ON_T), .BEEP_OFF_T(OFF_T),
    .BEEPS(NB), .SILENCE_T(SIL_T), .ESC_BURSTS(ESC)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Alarm(Alarm), .Ack(Ack),
    .Buzzer(Buzzer), .Lamp(Lamp), .Escalated(Escalated)
  );

  always #5 Clk = ~Clk;

  function automatic logic patEsc(input int k);
    return (k - 1) >= ESC_START;
  endfunction

  function automatic logic patBuzz(input int k);
    int j, pos;
    j = k - 1;
    if (j >= ESC_START) return ((j - ESC_START) % BEEP_LEN) < ON_T * TD;
    pos = j % CYCLE_LEN;
    return (pos < BURST_LEN) && ((pos % BEEP_LEN) < ON_T * TD);
  endfunction

  task automatic applyStimulus(input logic r, input logic a, input logic k);
    Rst = r;
    Alarm = a;
    Ack = k;
    @(posedge Clk);
    if (r || !a) begin
      mActive = 1'b0; mMuted = 1'b0; mK = 0;
    end else if (!mActive) begin
      mActive = 1'b1; mMuted = 1'b0; mK = 1;
    end else if (mMuted) begin
      mMuted = 1'b1;
    end else if (k && !patEsc(mK)) begin
      mMuted = 1'b1;
    end else begin
      mK++;
    end
    expLamp   = mActive;
    expBuzzer = mActive && !mMuted && patBuzz(mK);
    expEsc    = mActive && !mMuted && patEsc(mK);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      vectors++;
      if ({Buzzer, Lamp, Escalated} !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL reset cyc=%0d got B/L/E=%b%b%b expected 000", i, Buzzer, Lamp, Escalated);
      end
    end
  endtask

  task automatic test_basic_pattern();
    logic [17:0] buzzTable;
    buzzTable = 18'b111100111100000000;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      vectors++;
      if ({Buzzer, Lamp, Escalated} !== {buzzTable[17 - i], 1'b1, 1'b0} ||
          {Buzzer, Lamp, Escalated} !== {expBuzzer, expLamp, expEsc}) begin
        miscompares++;
        $display("[TB] FAIL basic k=%0d got B/L/E=%b%b%b expected %b10", mK, Buzzer, Lamp, Escalated, buzzTable[17 - i]);
      end
    end
  endtask

  task automatic test_escalation();
    for (int i = 0; i < 34; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      vectors++;
      if ({Buzzer, Lamp, Escalated} !== {expBuzzer, expLamp, expEsc}) begin
        miscompares++;
        $display("[TB] FAIL escalation k=%0d got B/L/E=%b%b%b expected %b%b%b", mK, Buzzer, Lamp, Escalated, expBuzzer, expLamp, expEsc);
      end
      if ((mK == 37 || mK == 49) && {Buzzer, Escalated} !== 2'b11) begin
        miscompares++;
        $display("[TB] FAIL escalation_edge k=%0d got B/E=%b%b expected 11", mK, Buzzer, Escalated);
      end
    end
  endtask

  task automatic test_ack_escalated();
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 52; i++) begin
      applyStimulus(1'b0, 1'b1, (mK == 39));
      vectors++;
      if ({Buzzer, Lamp, Escalated} !== {expBuzzer, expLamp, expEsc}) begin
        miscompares++;
        $display("[TB] FAIL ack_escalated k=%0d got B/L/E=%b%b%b expected %b%b%b", mK, Buzzer, Lamp, Escalated, expBuzzer, expLamp, expEsc);
      end
    end
  endtask

  task automatic test_mute();
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 110; i++) begin
      applyStimulus(1'b0, 1'b1, (i == 7));
      vectors++;
      if ({Buzzer, Lamp, Escalated} !== {expBuzzer, expLamp, expEsc} ||
          (i >= 7 && {Buzzer, Lamp} !== 2'b01)) begin
        miscompares++;
        $display("[TB] FAIL mute step=%0d got B/L/E=%b%b%b expected %b%b%b", i, Buzzer, Lamp, Escalated, expBuzzer, expLamp, expEsc);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    vectors++;
    if ({Buzzer, Lamp, Escalated} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL mute_release got B/L/E=%b%b%b expected 000", Buzzer, Lamp, Escalated);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    vectors++;
    if ({Buzzer, Lamp, Escalated} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL mute_restart got B/L/E=%b%b%b expected 110", Buzzer, Lamp, Escalated);
    end
  endtask

  task automatic test_alarm_drop();
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    vectors++;
    if ({Buzzer, Lamp, Escalated} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL alarm_drop got B/L/E=%b%b%b expected 000", Buzzer, Lamp, Escalated);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      vectors++;
      if ({Buzzer, Lamp, Escalated} !== {(i < 4), 1'b1, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL alarm_reraise step=%0d got B/L/E=%b%b%b expected %b10", i, Buzzer, Lamp, Escalated, (i < 4));
      end
    end
  endtask

  task automatic test_simultaneous();
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    vectors++;
    if ({Buzzer, Lamp, Escalated} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL rst_with_alarm got B/L/E=%b%b%b expected 000", Buzzer, Lamp, Escalated);
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, (i == 4));
      vectors++;
      if ({Buzzer, Lamp, Escalated} !== {expBuzzer, expLamp, expEsc} ||
          (i >= 4 && Buzzer !== 1'b0)) begin
        miscompares++;
        $display("[TB] FAIL ack_at_phase_end step=%0d got B/L/E=%b%b%b expected %b%b%b", i, Buzzer, Lamp, Escalated, expBuzzer, expLamp, expEsc);
      end
    end
  endtask

  task automatic test_random();
    logic r, a, k;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(499) == 0);
      a = ($urandom_range(149) != 0);
      k = ($urandom_range(59) == 0);
      applyStimulus(r, a, k);
      vectors++;
      if ({Buzzer, Lamp, Escalated} !== {expBuzzer, expLamp, expEsc}) begin
        miscompares++;
        $display("[TB] FAIL random i=%0d k=%0d got B/L/E=%b%b%b expected %b%b%b", i, mK, Buzzer, Lamp, Escalated, expBuzzer, expLamp, expEsc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_pattern();
    test_escalation();
    test_ack_escalated();
    test_mute();
    test_alarm_drop();
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
